// File: rtl/nco_pkg.sv
// Shared widths, state encoding and idle defaults for the NCO sweep controller.
package nco_pkg;

    localparam int unsigned FREQ_W  = 6;
    localparam int unsigned PHASE_W = 8;

    localparam logic [FREQ_W-1:0] IDLE_FREQ_DEF = FREQ_W'(1);

    typedef enum logic [1:0] {
        StIdle,
        StUp,
        StDown,
        StEnd
    } sweep_state_e;

endpackage

// File: rtl/nco_dwell_cnt.sv
// Loadable down-counter that tracks how long the current frequency step is held.
module nco_dwell_cnt #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - WIDTH'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Frequency-sweep sequencer feeding the NCO increment and start phase.
// Triangle sweeps (DOWN state, cfg_tri) are built only with NCO_SWEEP_TRIANGLE_EN defined.
module nco_sweep_ctrl
    import nco_pkg::*;
#(
    parameter int unsigned       DWELL_W   = 16,
    parameter logic [FREQ_W-1:0] IDLE_FREQ = IDLE_FREQ_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [FREQ_W-1:0]  cfg_f_start,
    input  logic [FREQ_W-1:0]  cfg_f_stop,
    input  logic [FREQ_W-1:0]  cfg_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [PHASE_W-1:0] cfg_phase,
    input  logic               cfg_repeat,
    input  logic               cfg_tri,
    output logic [FREQ_W-1:0]  freq_res,
    output logic [PHASE_W-1:0] phase,
    output logic               busy,
    output logic               done,
    output logic               wrap
);

    sweep_state_e state_q, state_d;

    logic [FREQ_W-1:0]  f_start_q, f_stop_q, step_q;
    logic [DWELL_W-1:0] dwell_q;
    logic               repeat_q;
    logic               tri_q;

    logic [FREQ_W-1:0]  freq_q, freq_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               busy_q, busy_d, done_q, done_d, wrap_q, wrap_d;

    logic               shadow_load;
    logic               cnt_load, cnt_dec, cnt_zero;
    logic [DWELL_W-1:0] cnt_val;
    logic [DWELL_W-1:0] cfg_dwell_m1;
    logic [FREQ_W-1:0]  cfg_step_eff;

    logic [FREQ_W:0]    up_sum, rise_sum, dn_diff;
    logic [FREQ_W-1:0]  up_next, rise_next, dn_next;
    logic               at_stop, at_start, tri_ok;

    // Zero dwell and zero step both behave as one.
    assign cfg_dwell_m1 = (cfg_dwell == '0) ? '0 : cfg_dwell - DWELL_W'(1);
    assign cfg_step_eff = (cfg_step == '0) ? FREQ_W'(1) : cfg_step;

    // Step arithmetic is one bit wider so overflow/underflow clamp instead of wrapping.
    assign up_sum    = {1'b0, freq_q} + {1'b0, step_q};
    assign up_next   = (up_sum > {1'b0, f_stop_q}) ? f_stop_q : up_sum[FREQ_W-1:0];
    assign rise_sum  = {1'b0, f_start_q} + {1'b0, step_q};
    assign rise_next = (rise_sum > {1'b0, f_stop_q}) ? f_stop_q : rise_sum[FREQ_W-1:0];
    assign dn_diff   = {1'b0, freq_q} - {1'b0, step_q};
    assign dn_next   = (dn_diff[FREQ_W] || (dn_diff[FREQ_W-1:0] < f_start_q)) ? f_start_q
                                                                              : dn_diff[FREQ_W-1:0];

    assign at_stop  = (freq_q >= f_stop_q);
    assign at_start = (freq_q <= f_start_q);

`ifdef NCO_SWEEP_TRIANGLE_EN
    assign tri_ok = tri_q && (f_start_q < f_stop_q);
`else
    logic unused_tri;
    assign unused_tri = cfg_tri;
    assign tri_q      = 1'b0;
    assign tri_ok     = 1'b0;
`endif

    nco_dwell_cnt #(
        .WIDTH(DWELL_W)
    ) u_dwell_cnt (
        .clk     (clk),
        .rst     (rst),
        .load    (cnt_load),
        .load_val(cnt_val),
        .dec     (cnt_dec),
        .zero    (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: if (start) state_d = StUp;
                StUp: begin
                    if (cnt_zero && at_stop) begin
                        if (tri_ok)        state_d = StDown;
                        else if (!repeat_q) state_d = StEnd;
                    end
                end
`ifdef NCO_SWEEP_TRIANGLE_EN
                StDown: begin
                    if (cnt_zero && at_start) state_d = repeat_q ? StUp : StEnd;
                end
`endif
                StEnd:   state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        freq_d      = freq_q;
        phase_d     = phase_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        wrap_d      = 1'b0;
        shadow_load = 1'b0;
        cnt_load    = 1'b0;
        cnt_val     = dwell_q;
        cnt_dec     = 1'b0;
        if (abort) begin
            freq_d = IDLE_FREQ;
            busy_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        shadow_load = 1'b1;
                        freq_d      = cfg_f_start;
                        phase_d     = cfg_phase;
                        busy_d      = 1'b1;
                        cnt_load    = 1'b1;
                        cnt_val     = cfg_dwell_m1;
                    end
                end
                StUp: begin
                    cnt_dec  = !cnt_zero;
                    cnt_load = cnt_zero;
                    if (cnt_zero) begin
                        if (!at_stop) begin
                            freq_d = up_next;
                        end else if (tri_ok) begin
                            freq_d = dn_next;
                            wrap_d = repeat_q && (dn_next == f_start_q);
                        end else if (repeat_q) begin
                            freq_d = f_start_q;
                            wrap_d = 1'b1;
                        end else begin
                            busy_d = 1'b0;
                            done_d = 1'b1;
                        end
                    end
                end
`ifdef NCO_SWEEP_TRIANGLE_EN
                StDown: begin
                    cnt_dec  = !cnt_zero;
                    cnt_load = cnt_zero;
                    if (cnt_zero) begin
                        // Wrap marks arrival back at f_start; the bottom value is not repeated.
                        if (!at_start) begin
                            freq_d = dn_next;
                            wrap_d = repeat_q && (dn_next == f_start_q);
                        end else if (repeat_q) begin
                            freq_d = rise_next;
                        end else begin
                            busy_d = 1'b0;
                            done_d = 1'b1;
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            freq_q    <= IDLE_FREQ;
            phase_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wrap_q    <= 1'b0;
            f_start_q <= '0;
            f_stop_q  <= '0;
            step_q    <= FREQ_W'(1);
            dwell_q   <= '0;
            repeat_q  <= 1'b0;
        end else begin
            freq_q  <= freq_d;
            phase_q <= phase_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
            if (shadow_load) begin
                f_start_q <= cfg_f_start;
                f_stop_q  <= cfg_f_stop;
                step_q    <= cfg_step_eff;
                dwell_q   <= cfg_dwell_m1;
                repeat_q  <= cfg_repeat;
            end
        end
    end

`ifdef NCO_SWEEP_TRIANGLE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tri_q <= 1'b0;
        end else if (shadow_load) begin
            tri_q <= cfg_tri;
        end
    end
`endif

    assign freq_res = freq_q;
    assign phase    = phase_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign wrap     = wrap_q;

endmodule

// File: doc/nco_sweep_ctrl.md
Name: nco_sweep_ctrl

Overview:
- Frequency-sweep sequencer that drives the 6-bit frequency-increment and 8-bit start-phase inputs of the NCO.
- On a start pulse it latches a sweep configuration, loads the start phase, then steps the increment from f_start to f_stop by step, holding each value for dwell cycles.
- Supports single-shot, continuous-repeat and (optionally) triangle sweeps. Reports busy/done/wrap status to the system controller.

Parameters:
- DWELL_W, 16, width of the dwell counter (cycles per frequency step).
- IDLE_FREQ, 1, freq_res value driven after reset and after abort (matches NCO reset increment).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  start request; sampled only in IDLE
- abort  in  1  stop sweep immediately; priority over everything except rst
- cfg_f_start  in  6  first increment
- cfg_f_stop  in  6  last increment
- cfg_step  in  6  increment step; 0 treated as 1
- cfg_dwell  in  DWELL_W  cycles per step; 0 treated as 1
- cfg_phase  in  8  start phase presented to the NCO
- cfg_repeat  in  1  1 = restart sweep continuously
- cfg_tri  in  1  1 = triangle mode (only with the optional feature)
- freq_res  out  6  to NCO freq_res
- phase  out  8  to NCO phase
- busy  out  1  sweep in progress
- done  out  1  1-cycle pulse at end of a single-shot sweep
- wrap  out  1  1-cycle pulse when a repeat sweep restarts

Behaviour:
- All outputs registered. On reset: freq_res=IDLE_FREQ, phase=0, busy=0, done=0, wrap=0, FSM=IDLE. Reset mid-sweep behaves identically.
- FSM states: IDLE, UP, DOWN, END.
- IDLE:
  - start=1 (and abort=0): latch all cfg_* into shadow registers.
  - Next edge: freq_res=f_start, phase=cfg_phase, busy=1, dwell counter=max(dwell,1)-1, go UP.
  - cfg_* changes after start have no effect until the next start. start while busy is ignored.
- UP:
  - Dwell counter decrements each cycle. When it is 0 and freq_res != f_stop: next=freq_res+step computed at 7 bits; if next > f_stop, freq_res=f_stop, else freq_res=next. Reload dwell.
  - When dwell is 0 and freq_res == f_stop:
    - tri=1: go DOWN.
    - else repeat=1: freq_res=f_start, wrap=1 for one cycle, reload dwell, stay UP.
    - else: go END.
- DOWN:
  - Mirror of UP. next=freq_res-step, signed 7-bit; if next < f_start, freq_res=f_start.
  - At f_start with dwell expired: repeat=1 gives wrap pulse and continues UP from f_start+step (f_start is not repeated); else go END.
- END: one cycle. done=1, busy=0, freq_res holds last value, phase holds, then IDLE.
- Degenerate f_start >= f_stop: single value f_start is held for one dwell period, then END (or wrap if repeat). Triangle skips DOWN.
- abort: next edge goes to IDLE with busy=0 and freq_res=IDLE_FREQ, phase held, no done pulse. abort and start in the same cycle: abort wins.
- Phase note: the NCO reloads phase only when its phase input changes value. The controller drives cfg_phase once per start and does not force a change.
- Latency: first new freq_res is visible 1 cycle after start. Each value is held exactly max(dwell,1) cycles.

Optional Feature:
- Macro NCO_SWEEP_TRIANGLE_EN.
- Defined: the DOWN state and the cfg_tri behaviour above are present.
- Undefined: cfg_tri is ignored, the DOWN state is not built, and the block is sawtooth-only.

Decomposition:
- Shared package nco_pkg: FREQ_W=6, PHASE_W=8, FSM state enum (IDLE/UP/DOWN/END), IDLE_FREQ default.
- One natural sub-module: nco_dwell_cnt (loadable down-counter with zero flag). Step/clamp arithmetic stays inline.

Test Plan:
- f_start=4, f_stop=10, step=3, dwell=2, repeat=0: freq_res 4,4,7,7,10,10, then done pulse. busy high exactly 6 cycles, then returns to 0.
- f_start=60, f_stop=63, step=5, dwell=1: sequence 60,63, then done. Confirms clamp on 7-bit overflow.
- repeat=1, f_start=1, f_stop=3, step=1, dwell=1: 1,2,3,1,2,3…, with wrap pulse coincident with each return to 1. done is never asserted.
- Abort during the dwell of value 7 in the first scenario: next cycle freq_res=1, busy=0, no done. A new start 2 cycles later restarts from 4.
- step=0, dwell=0, f_start=5, f_stop=7: 5,6,7 at one cycle each. Then f_start=9, f_stop=2: holds 9 for one cycle, then done.
- With NCO_SWEEP_TRIANGLE_EN, tri=1, 2→6 step 2 dwell 1, repeat=1: 2,4,6,4,2(wrap),4,6,… Without the macro the same stimulus gives the sawtooth 2,4,6,2(wrap)….
